// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline MEM/WB slice.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic reg_write;
  } wb_ctrl_t;

  // Control pattern loaded into MEM/WB when no instruction retires this cycle.
  localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0};

  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a new instruction or a bubble that
// clears RegWrite while holding destination and data.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bubble,
  input  logic                  reg_write_d,
  input  logic [REG_ADDR_W-1:0] rw_d,
  input  logic [WORD_W-1:0]     wb_data_d,
  output logic                  reg_write_q,
  output logic [REG_ADDR_W-1:0] rw_q,
  output logic [WORD_W-1:0]     wb_data_q
);

  wb_ctrl_t                ctrl_reg;
  logic [REG_ADDR_W-1:0]   rw_reg;
  logic [WORD_W-1:0]       wb_data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_reg    <= WB_BUBBLE;
      rw_reg      <= '0;
      wb_data_reg <= '0;
    end else if (bubble) begin
      ctrl_reg    <= WB_BUBBLE;
    end else begin
      ctrl_reg.reg_write <= reg_write_d;
      rw_reg             <= rw_d;
      wb_data_reg        <= wb_data_d;
    end
  end

  assign reg_write_q = ctrl_reg.reg_write;
  assign rw_q        = rw_reg;
  assign wb_data_q   = wb_data_reg;

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage with MEM/WB register, stall FSM and stall counter.
// Optional MEM_ALIGN_CHECK_EN drops misaligned accesses and flags misalign_err.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemtoReg_in,
  input  logic                   RegWrite_in,
  input  logic                   MemRead_in,
  input  logic                   MemWrite_in,
  input  logic [WORD_W-1:0]      ALU_Result_in,
  input  logic [WORD_W-1:0]      busB_in,
  input  logic [REG_ADDR_W-1:0]  RW_in,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [WORD_W-1:0]      mem_addr,
  output logic [WORD_W-1:0]      mem_wdata,
  input  logic                   mem_ack,
  input  logic [WORD_W-1:0]      mem_rdata,
  output logic                   stall,
  output logic                   RegWrite_out,
  output logic [REG_ADDR_W-1:0]  RW_out,
  output logic [WORD_W-1:0]      WB_data_out,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   misalign_err
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

  logic                   acc;
  logic                   misalign;
  logic                   acc_valid;
  logic [WORD_W-1:0]      wb_data_next;
  mem_state_t             state_reg;
  logic [STALL_CNT_W-1:0] stall_cycles_reg;

  assign acc = MemRead_in | MemWrite_in;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_err_reg;

  assign misalign = acc & is_misaligned(ALU_Result_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_err_reg <= 1'b0;
    else        misalign_err_reg <= misalign;
  end

  assign misalign_err = misalign_err_reg;
`else
  assign misalign     = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // A dropped (misaligned) access never reaches memory and never stalls.
  assign acc_valid = acc & ~misalign;
  assign mem_req   = acc_valid;
  assign mem_we    = MemWrite_in;
  assign mem_addr  = ALU_Result_in;
  assign mem_wdata = busB_in;
  assign stall     = acc_valid & ~mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (acc_valid && !mem_ack) state_reg <= BUSY;
        BUSY:    if (mem_ack || !acc_valid) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cycles_reg <= '0;
    else if (stall && stall_cycles_reg != '1)
      stall_cycles_reg <= stall_cycles_reg + CNT_ONE;
  end

  assign stall_cycles = stall_cycles_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_wb_sel
      assign wb_data_next[gi] = MemtoReg_in ? mem_rdata[gi] : ALU_Result_in[gi];
    end
  endgenerate

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .reset       (reset),
    .bubble      (stall | misalign),
    .reg_write_d (RegWrite_in),
    .rw_d        (RW_in),
    .wb_data_d   (wb_data_next),
    .reg_write_q (RegWrite_out),
    .rw_q        (RW_out),
    .wb_data_q   (WB_data_out)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a transaction-level model.
module tb_mem_wb_stage;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in;
  logic [31:0]      ALU_Result_in, busB_in;
  logic [4:0]       RW_in;
  logic             mem_req, mem_we;
  logic [31:0]      mem_addr, mem_wdata;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  logic             stall, RegWrite_out;
  logic [4:0]       RW_out;
  logic [31:0]      WB_data_out;
  logic [CNT_W-1:0] stall_cycles;
  logic             misalign_err;

  always #5 clk = ~clk;

  mem_wb_stage #(.STALL_CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .ALU_Result_in(ALU_Result_in), .busB_in(busB_in), .RW_in(RW_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .RegWrite_out(RegWrite_out), .RW_out(RW_out), .WB_data_out(WB_data_out),
    .stall_cycles(stall_cycles), .misalign_err(misalign_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Architectural view of what the WB stage should currently hold.
  logic        m_regw;
  logic [4:0]  m_rw;
  logic [31:0] m_wb;
  int          m_cnt;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
  endtask

  task automatic drive_zero();
    MemtoReg_in = 1'b0; RegWrite_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
    ALU_Result_in = '0; busB_in = '0; RW_in = '0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic check_wb(input string name);
    check({name, ".RegWrite_out"}, 32'(RegWrite_out), 32'(m_regw));
    check({name, ".RW_out"},       32'(RW_out),       32'(m_rw));
    check({name, ".WB_data_out"},  WB_data_out,       m_wb);
    check({name, ".stall_cycles"}, 32'(stall_cycles), 32'(m_cnt));
    check({name, ".misalign_err"}, 32'(misalign_err), 32'(m_err));
  endtask

  // One instruction through MEM: held stable until acked 'waits' cycles later.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic regw, input logic m2r, input logic [31:0] alu,
                         input logic [31:0] busb, input logic [4:0] rw, input int waits);
    logic        acc, mis;
    int          n;
    logic [31:0] rdata_last;
    acc = rd | wr;
    mis = ALIGN && acc && (alu[1:0] != 2'b00);
    n   = (acc && !mis) ? waits : 0;
    rdata_last = '0;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      MemRead_in = rd; MemWrite_in = wr; RegWrite_in = regw; MemtoReg_in = m2r;
      ALU_Result_in = alu; busB_in = busb; RW_in = rw;
      mem_rdata = $urandom;
      mem_ack = acc ? (k == n) : 1'($urandom_range(0, 1));
      rdata_last = mem_rdata;
      #1;
      check({name, ".mem_req"}, 32'(mem_req), 32'(acc && !mis));
      check({name, ".stall"},   32'(stall),   32'(k < n));
      if (acc && !mis) begin
        check({name, ".mem_we"},    32'(mem_we), 32'(wr));
        check({name, ".mem_addr"},  mem_addr,    alu);
        check({name, ".mem_wdata"}, mem_wdata,   busb);
      end
      @(posedge clk);
      #1;
      if (k < n) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        m_regw = 1'b0;
        m_err  = 1'b0;
        check_wb({name, ".bubble"});
      end
    end
    m_err = mis;
    if (mis) begin
      m_regw = 1'b0;
    end else begin
      m_regw = regw;
      m_rw   = rw;
      m_wb   = m2r ? rdata_last : alu;
    end
    check_wb(name);
    $display("txn %-10s rd=%0b wr=%0b addr=%08h waits=%0d -> regw=%0b rw=%0d wb=%08h cnt=%0d err=%0b",
             name, rd, wr, alu, n, RegWrite_out, RW_out, WB_data_out, stall_cycles, misalign_err);
  endtask

  initial begin
    drive_zero();
    reset = 1'b0;
    m_regw = 1'b0; m_rw = '0; m_wb = '0; m_cnt = 0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_wb("reset");
    check("reset.stall",   32'(stall),   32'd0);
    check("reset.mem_req", 32'(mem_req), 32'd0);
    reset = 1'b1;

    run_txn("rtype",  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0,          5'd8,  0);
    run_txn("load0",  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0,          5'd9,  0);
    run_txn("store3", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5'd0,  3);
    run_txn("satur",  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0,          5'd12, 20);
    run_txn("misal",  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0,          5'd5,  1);
    run_txn("afterm", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0077, 32'h0,          5'd6,  0);
    run_txn("both",   1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h1111_2222, 5'd7,  2);

    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      logic        rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ((rd | wr) && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn("rand", rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              a, $urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 4)));
    end

    // Reset arriving two cycles into a five-cycle load.
    @(negedge clk);
    MemRead_in = 1'b1; MemtoReg_in = 1'b1; RegWrite_in = 1'b1; RW_in = 5'd3;
    ALU_Result_in = 32'h0000_0040; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    drive_zero();
    #1;
    m_regw = 1'b0; m_rw = '0; m_wb = '0; m_cnt = 0; m_err = 1'b0;
    check_wb("rst_busy");
    check("rst_busy.mem_req", 32'(mem_req), 32'd0);
    check("rst_busy.stall",   32'(stall),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = (i == 2);
      mem_rdata = 32'hBAD0_BAD0;
      #1;
      check("late_ack.stall",   32'(stall),   32'd0);
      check("late_ack.mem_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      check("late_ack.RegWrite_out", 32'(RegWrite_out), 32'd0);
      check("late_ack.stall_cycles", 32'(stall_cycles), 32'd0);
    end
    $display("txn rst_busy  reset mid-access, late ack ignored -> regw=%0b cnt=%0d",
             RegWrite_out, stall_cycles);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs, performs loads/stores over a ready/acknowledge data-memory port, stalls the pipeline while an access is outstanding, and registers the write-back data, destination and RegWrite for the WB stage and forwarding unit. It sits between the EX/MEM register and the register file write port.

## Interface
Parameters:
- `STALL_CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemtoReg_in`, `RegWrite_in`, `MemRead_in`, `MemWrite_in`  in  1 each  control bits from EX/MEM.
- `ALU_Result_in`  in  32  memory address, or the ALU result for write-back.
- `busB_in`  in  32  store data.
- `RW_in`  in  5  destination register.
- `mem_req`  out  1  data-memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  32  byte address.
- `mem_wdata`  out  32  store data.
- `mem_ack`  in  1  access complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  load data.
- `stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- `RegWrite_out`  out  1  registered write enable to the register file.
- `RW_out`  out  5  registered destination.
- `WB_data_out`  out  32  registered write-back data.
- `stall_cycles`  out  `STALL_CNT_W`  saturating count of stalled cycles.
- `misalign_err`  out  1  registered one-cycle error pulse (only with `MEM_ALIGN_CHECK_EN`).

## Operation
- Access request: `acc = MemRead_in | MemWrite_in`. If both bits are set, the access is a write.
- FSM states:
  - IDLE.
    - `acc & mem_ack`: the access completes this cycle; stay in IDLE.
    - `acc & ~mem_ack`: go to BUSY.
    - Otherwise: pass-through.
  - BUSY.
    - `mem_ack`: the access completes; go to IDLE.
    - Otherwise: stay in BUSY.
- `mem_req = acc` in both states.
- `mem_we`, `mem_addr` and `mem_wdata` are driven combinationally from `MemWrite_in`, `ALU_Result_in` and `busB_in`.
- `stall = acc & ~mem_ack`.
  - While stalled, EX/MEM holds its values, so the request stays stable until ack.
- `mem_ack` is ignored when `mem_req` = 0.
- MEM/WB update on each edge:
  - Not stalled: load `RegWrite_in`, `RW_in`, and `WB_data = MemtoReg_in ? mem_rdata : ALU_Result_in`.
  - Stalled: load a bubble (`RegWrite_out` = 0; `RW_out` and `WB_data_out` keep their previous values).
- Stores never write back unless `RegWrite_in` = 1.
- `stall_cycles` increments on each edge where `stall` = 1 and saturates at all-ones.

## Timing
- Reset values: state IDLE; `RegWrite_out` 0; `RW_out` 0; `WB_data_out` 0; `stall_cycles` 0; `misalign_err` 0.
- Reset asserted mid-access: the FSM returns to IDLE immediately. `mem_req` follows the (reset) EX/MEM inputs and falls to 0.
- Latency:
  - Non-memory ops and zero-wait accesses: one cycle from EX/MEM output to MEM/WB output.
  - An access acked N cycles after the request: `stall` is high for N cycles, then the result appears one edge after ack.
- Back-to-back accesses: a new request may be presented in the cycle after ack, with no idle cycle required.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A misaligned access (`acc` with `ALU_Result_in[1:0] != 0`) forces `mem_req` = 0 and `stall` = 0.
  - MEM/WB loads a bubble.
  - `misalign_err` pulses for one cycle on the following edge.
  - The misaligned access counts as a completed access.
- `MEM_ALIGN_CHECK_EN` undefined:
  - There is no check; `misalign_err` is tied to 0.
  - Address bits [1:0] are passed to memory unchanged.

## Structure
- Shared package `mips_pkg`:
  - FSM state typedef (IDLE/BUSY).
  - Constants `WORD_W` = 32 and `REG_ADDR_W` = 5.
  - Bubble constant for the MEM/WB control bits.
- One sub-module: `mem_wb_reg`, the MEM/WB register with load/bubble select and asynchronous active-low reset.
- The FSM, request logic and counter live in `mem_wb_stage`.

## Test plan
- Reset mid-BUSY:
  - Stimulus: load with addr 0x40 and ack delayed 5 cycles; assert reset in cycle 2.
  - Required response: state IDLE immediately; `RegWrite_out` 0; `stall_cycles` 0; the late ack is ignored.
- R-type pass-through:
  - Stimulus: RegWrite=1, MemtoReg=0, ALU=0x1234, RW=8.
  - Required response: next edge `WB_data_out`=0x1234, `RW_out`=8, `RegWrite_out`=1; `mem_req`=0; `stall`=0.
- Zero-wait load:
  - Stimulus: MemRead=1, MemtoReg=1, addr 0x100, `mem_ack`=1 same cycle, `rdata`=0xDEADBEEF, RW=9.
  - Required response: no stall; next edge `WB_data_out`=0xDEADBEEF.
- Store with 3 wait cycles:
  - Stimulus: MemWrite=1, addr 0x200, busB=0xCAFEF00D, ack after 3 cycles.
  - Required response: `mem_we`=1; `stall` high for 3 cycles; bubbles in MEM/WB; `stall_cycles` reaches 3.
- Counter saturation:
  - Stimulus: `STALL_CNT_W`=4; 20 stalled cycles.
  - Required response: `stall_cycles` holds at 15.
- Misalignment:
  - With `MEM_ALIGN_CHECK_EN`, load at addr 0x102: `mem_req`=0; `misalign_err` pulses once; `RegWrite_out`=0.
  - Without the macro, the same load: `mem_req`=1 with addr 0x102.
